// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the ram_ctrl host-side RAM controller.
package ram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 4;

    // Controller FSM states.
    typedef enum logic [2:0] {
        START = 3'd0,   // reset state, everything idle
        INIT  = 3'd1,   // zero-fill sweep over the whole array
        IDLE  = 3'd2,   // ready for a host request, bus released
        WRITE = 3'd3,   // one-cycle write of the captured word
        READ  = 3'd4,   // one-cycle read, RAM drives the bus
        RESP  = 3'd5    // holding read data until the host takes it
    } state_e;

endpackage

// File: rtl/ram_ctrl.sv
// Host-side controller for a single-port RAM with a bidirectional data bus.
// Zero-fills the array after reset, then serves one read or write at a time.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,

    output logic                  init_done,

    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wr_en,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    state_e                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q,  init_cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q,      addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    init_done_q, init_done_d;
    logic [DATA_WIDTH-1:0]   drive_data;

    // Next-state and capture logic for the whole controller.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        init_done_d = init_done_q;

        case (state_q)
            START: begin
                init_cnt_d = '0;
                state_d    = INIT;
            end
            INIT: begin
                // Stop on all-ones rather than relying on the counter wrapping.
                if (init_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                // The RAM drives the bus combinationally for the whole cycle.
                rsp_rdata_d = ram_data;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= START;
            init_cnt_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            init_done_q <= init_done_d;
        end
    end

    // Moore decodes of the registered state; no host input reaches the RAM pins.
    always_comb begin
        req_ready  = (state_q == IDLE);
        rsp_valid  = (state_q == RESP);
        ram_wr_en  = (state_q == INIT) || (state_q == WRITE);
        ram_addr   = (state_q == INIT) ? init_cnt_q : addr_q;
        drive_data = (state_q == WRITE) ? wdata_q : '0;
    end

    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

    // The controller owns the bus only while writing; otherwise the RAM drives it.
    assign ram_data = ram_wr_en ? drive_data : {DATA_WIDTH{1'bz}};

endmodule
